// File: rtl/shift_seq_if.sv
// shift_seq_if: request/response handshake bundle between ALU issue logic and shift_seq_ctrl
interface shift_seq_if #(parameter int N = 16, parameter int C = 4);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [N-1:0] req_data;
  logic [C-1:0] req_cnt;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_data;
  modport master (output req_valid, req_op, req_data, req_cnt, resp_ready,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_op, req_data, req_cnt, resp_ready,
                  output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: SRL/SLL/SRA/ROR sequencer built on a shared combinational right shifter.
// Define SHIFT_SEQ_ZERO_BYPASS_EN to answer zero-count requests straight from IDLE.
module shift_seq_ctrl #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_seq_if.slave   bus,
  output logic [N-1:0] sh_in,
  output logic [C-1:0] sh_cnt,
  input  logic [N-1:0] sh_out
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
  typedef enum logic [1:0] {SRL, SLL, SRA, ROR} op_t;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) bitrev[i] = v[N-1-i];
  endfunction

  state_t       state_q, state_d;
  op_t          op_q, op_d, req_op;
  logic [N-1:0] x_q, x_d, a_q, a_d, resp_data_q, resp_data_d, sh_in_q, sh_in_d;
  logic [C-1:0] n_q, n_d, sh_cnt_q, sh_cnt_d;
  logic         req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, bypass;
  logic [N-1:0] req_pre, pass1_res;

  assign req_op = op_t'(bus.req_op);
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
  assign bypass = bus.req_cnt == '0;
`else
  assign bypass = 1'b0;
`endif
  // Left and arithmetic shifts are mapped onto the right shifter by reversing or inverting around it
  assign req_pre   = req_op == SLL ? bitrev(bus.req_data)
                   : (req_op == SRA && bus.req_data[N-1]) ? ~bus.req_data : bus.req_data;
  assign pass1_res = op_q == SLL ? bitrev(sh_out)
                   : (op_q == SRA && x_q[N-1]) ? ~sh_out
                   : op_q == ROR ? x_q : sh_out;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    x_d          = x_q;
    n_d          = n_q;
    a_d          = a_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    sh_in_d      = sh_in_q;
    sh_cnt_d     = sh_cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d        = req_op;
        x_d         = bus.req_data;
        n_d         = bus.req_cnt;
        req_ready_d = 1'b0;
        if (bypass) begin
          state_d      = RESP;
          resp_data_d  = bus.req_data;
          resp_valid_d = 1'b1;
        end else begin
          state_d  = PASS1;
          sh_in_d  = req_pre;
          sh_cnt_d = bus.req_cnt;
        end
      end
      PASS1: if (op_q == ROR && n_q != '0) begin
        // Second pass recovers the bits shifted out: bitrev(bitrev(X) >> (N-n)) == X << (N-n)
        a_d      = sh_out;
        sh_in_d  = bitrev(x_q);
        sh_cnt_d = C'(N - int'(n_q));
        state_d  = PASS2;
      end else begin
        resp_data_d  = pass1_res;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      PASS2: begin
        resp_data_d  = a_q | bitrev(sh_out);
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: if (bus.resp_ready) begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= SRL;
      x_q          <= '0;
      n_q          <= '0;
      a_q          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      sh_in_q      <= '0;
      sh_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      x_q          <= x_d;
      n_q          <= n_d;
      a_q          <= a_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      sh_in_q      <= sh_in_d;
      sh_cnt_q     <= sh_cnt_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign sh_in          = sh_in_q;
  assign sh_cnt         = sh_cnt_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed checks of shift_seq_ctrl against a behavioural right shifter
module tb_shift_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sh_in, sh_out;
  logic [3:0]  sh_cnt;
  int total = 0;
  int bad = 0;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 2;
`endif

  shift_seq_if bus ();
  shift_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_out(sh_out));

  assign sh_out = sh_in >> sh_cnt;
  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c,
                       output int lat, output logic [3:0] c1, output logic [3:0] c2, output logic [15:0] s1);
    int k = 0;
    while (!bus.req_ready && k < 20) begin @(posedge clk); #1; k++; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d; bus.req_cnt = c;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    c1 = sh_cnt; s1 = sh_in; c2 = sh_cnt; lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) c2 = sh_cnt;
    end
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_data !== 16'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0000", bus.resp_data); end
    total++; if (sh_in !== 16'h0 || sh_cnt !== 4'h0) begin bad++; $display("FAIL rst_sh got=%h/%h exp=0000/0", sh_in, sh_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_srl();
    int lat; logic [3:0] c1, c2; logic [15:0] s1;
    issue(2'b00, 16'h8421, 4'd4, lat, c1, c2, s1);
    total++; if (lat !== 2) begin bad++; $display("FAIL srl_latency got=%0d exp=2", lat); end
    total++; if (c1 !== 4'd4) begin bad++; $display("FAIL srl_sh_cnt got=%0d exp=4", c1); end
    total++; if (bus.resp_data !== 16'h0842) begin bad++; $display("FAIL srl_data got=%h exp=0842", bus.resp_data); end
    take_resp();
  endtask

  task automatic test_sll();
    int lat; logic [3:0] c1, c2; logic [15:0] s1;
    issue(2'b01, 16'h00F1, 4'd8, lat, c1, c2, s1);
    total++; if (s1 !== 16'h8F00) begin bad++; $display("FAIL sll_sh_in got=%h exp=8f00", s1); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sll_latency got=%0d exp=2", lat); end
    total++; if (bus.resp_data !== 16'hF100) begin bad++; $display("FAIL sll_data got=%h exp=f100", bus.resp_data); end
    take_resp();
  endtask

  task automatic test_sra();
    int lat; logic [3:0] c1, c2; logic [15:0] s1;
    issue(2'b10, 16'h8000, 4'd3, lat, c1, c2, s1);
    total++; if (bus.resp_data !== 16'hF000) begin bad++; $display("FAIL sra_neg_data got=%h exp=f000", bus.resp_data); end
    take_resp();
    issue(2'b10, 16'h4000, 4'd3, lat, c1, c2, s1);
    total++; if (bus.resp_data !== 16'h0800) begin bad++; $display("FAIL sra_pos_data got=%h exp=0800", bus.resp_data); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sra_latency got=%0d exp=2", lat); end
    take_resp();
  endtask

  task automatic test_ror();
    int lat; logic [3:0] c1, c2; logic [15:0] s1;
    issue(2'b11, 16'h1234, 4'd4, lat, c1, c2, s1);
    total++; if (lat !== 3) begin bad++; $display("FAIL ror_latency got=%0d exp=3", lat); end
    total++; if (c1 !== 4'd4) begin bad++; $display("FAIL ror_pass1_cnt got=%0d exp=4", c1); end
    total++; if (c2 !== 4'd12) begin bad++; $display("FAIL ror_pass2_cnt got=%0d exp=12", c2); end
    total++; if (bus.resp_data !== 16'h4123) begin bad++; $display("FAIL ror_data got=%h exp=4123", bus.resp_data); end
    take_resp();
    issue(2'b11, 16'hABCD, 4'd0, lat, c1, c2, s1);
    total++; if (lat !== ZLAT) begin bad++; $display("FAIL ror0_latency got=%0d exp=%0d", lat, ZLAT); end
    total++; if (bus.resp_data !== 16'hABCD) begin bad++; $display("FAIL ror0_data got=%h exp=abcd", bus.resp_data); end
    take_resp();
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] c1, c2; logic [15:0] s1;
    issue(2'b00, 16'hFFFF, 4'd15, lat, c1, c2, s1);
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.resp_data !== 16'h0001 || bus.resp_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h/v%b exp=0001/v1", i, bus.resp_data, bus.resp_valid); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_data = 16'h00F0; bus.req_cnt = 4'd4;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_after_hs got=rdy%b/v%b exp=rdy1/v0", bus.req_ready, bus.resp_valid); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", bus.req_ready); end
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 2 || bus.resp_data !== 16'h000F) begin
      bad++; $display("FAIL b2b_second got=lat%0d/%h exp=lat2/000f", lat, bus.resp_data); end
    take_resp();
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_data = 16'h1234; bus.req_cnt = 4'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (sh_cnt !== 4'd12) begin bad++; $display("FAIL mid_in_pass2 got=%0d exp=12", sh_cnt); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'h0) begin
      bad++; $display("FAIL mid_abort got=v%b/%h exp=v0/0000", bus.resp_valid, bus.resp_data); end
    total++; if (bus.req_ready !== 1'b1 || sh_cnt !== 4'd0) begin
      bad++; $display("FAIL mid_abort_ctl got=rdy%b/cnt%0d exp=rdy1/cnt0", bus.req_ready, sh_cnt); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        bad++; $display("FAIL mid_no_stale cyc=%0d got=v%b/rdy%b exp=v0/rdy1", i, bus.resp_valid, bus.req_ready); end
    end
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 16'h0; bus.req_cnt = 4'h0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_srl();
    test_sll();
    test_sra();
    test_ror();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
